accelerator_allocation_weighting_sorter: RTL and testbench

Parametrised DNC allocation-weighting engine: loads a usage vector u(t) of up to MAX_N fixed-point words and derives the free list phi(t) by stable ascending sort. It computes a(t)[phi[j]] = (1 - u[phi[j]]) · prod_{i<j} u[phi[i]] and streams a(t) back in original index order. It sits in the DNC memory path, beside usage/write-weighting blocks, and is self-contained: no external adder, multiplier or sort sub-accelerators.

---
 rtl/accelerator_dnc_pkg.sv | 12 +
 rtl/accelerator_fixed_multiplier.sv | 11 +
 rtl/accelerator_allocation_weighting_sorter.sv | 132 +++++++++++++
 tb/tb_accelerator_allocation_weighting_sorter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/accelerator_dnc_pkg.sv
// accelerator_dnc_pkg: shared DNC fixed-point constants, FSM state type and multiply helper
package accelerator_dnc_pkg;
  localparam int DNC_DATA_SIZE = 16;
  localparam int DNC_FRAC_BITS = 15;
  localparam int DNC_MAX_N = 16;
  localparam int DNC_IDX_W = $clog2(DNC_MAX_N);
  localparam logic [DNC_DATA_SIZE-1:0] DNC_ONE = DNC_DATA_SIZE'(1) << DNC_FRAC_BITS;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, COMPUTE, OUTPUT, DONE} state_t;
  function automatic logic [DNC_DATA_SIZE-1:0] fx_mul(input logic [DNC_DATA_SIZE-1:0] a, input logic [DNC_DATA_SIZE-1:0] b);
    return DNC_DATA_SIZE'(({{DNC_DATA_SIZE{1'b0}}, a} * {{DNC_DATA_SIZE{1'b0}}, b}) >> DNC_FRAC_BITS);
  endfunction
endpackage

// File: rtl/accelerator_fixed_multiplier.sv
// accelerator_fixed_multiplier: combinational W x W fixed-point product, shifted by F and truncated to W bits
module accelerator_fixed_multiplier #(
  parameter int W = 16,
  parameter int F = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> F);
endmodule

// File: rtl/accelerator_allocation_weighting_sorter.sv
// accelerator_allocation_weighting_sorter: DNC allocation weighting via stable min-scan sort; ACCELERATOR_ALLOCATION_WEIGHTING_CLAMP_EN saturates loaded usage to ONE
module accelerator_allocation_weighting_sorter
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE = DNC_DATA_SIZE,
  parameter int FRAC_BITS = DNC_FRAC_BITS,
  parameter int MAX_N = DNC_MAX_N
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 BUSY,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic                 U_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] U_IN,
  output logic                 PHI_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] PHI_OUT,
  output logic                 A_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] A_OUT
);
  localparam int CW = $clog2(MAX_N + 1);
  localparam int IW = MAX_N > 1 ? $clog2(MAX_N) : 1;
  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRAC_BITS;
  state_t state;
  logic [DATA_SIZE-1:0] u_buf [MAX_N];
  logic [DATA_SIZE-1:0] a_buf [MAX_N];
  logic [MAX_N-1:0] used;
  logic [CW-1:0] n, cnt, j, k, o, n_in;
  logic [IW-1:0] mi;
  logic [DATA_SIZE-1:0] mv, p, u_cur, u_load, a_new, p_new;
  logic found, cand;
  assign n_in = 32'(SIZE_N_IN) > MAX_N ? CW'(MAX_N) : CW'(SIZE_N_IN);
  assign u_cur = u_buf[j[IW-1:0]];
  assign cand = !used[j[IW-1:0]] && (!found || u_cur < mv);
`ifdef ACCELERATOR_ALLOCATION_WEIGHTING_CLAMP_EN
  assign u_load = U_IN > ONE ? ONE : U_IN;
`else
  assign u_load = U_IN;
`endif
  accelerator_fixed_multiplier #(.W(DATA_SIZE), .F(FRAC_BITS)) mul_a (.a(ONE - u_buf[mi]), .b(p), .y(a_new));
  accelerator_fixed_multiplier #(.W(DATA_SIZE), .F(FRAC_BITS)) mul_p (.a(u_buf[mi]), .b(p), .y(p_new));
  // Outputs are loaded on the edge entering the cycle they belong to, so strobes line up with the state they report
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      READY <= 1'b0;
      BUSY <= 1'b0;
      PHI_OUT_ENABLE <= 1'b0;
      PHI_OUT <= '0;
      A_OUT_ENABLE <= 1'b0;
      A_OUT <= '0;
      used <= '0;
      n <= '0;
      cnt <= '0;
      j <= '0;
      k <= '0;
      o <= '0;
      mi <= '0;
      mv <= '0;
      p <= ONE;
      found <= 1'b0;
    end else begin
      READY <= 1'b0;
      PHI_OUT_ENABLE <= 1'b0;
      A_OUT_ENABLE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          BUSY <= 1'b1;
          n <= n_in;
          used <= '0;
          p <= ONE;
          cnt <= '0;
          k <= '0;
          o <= '0;
          state <= n_in == '0 ? OUTPUT : LOAD;
        end
        LOAD: if (U_IN_ENABLE) begin
          u_buf[cnt[IW-1:0]] <= u_load;
          cnt <= cnt + 1'b1;
          if (cnt == n - 1'b1) begin
            state <= SCAN;
            j <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          if (cand) begin
            mi <= j[IW-1:0];
            mv <= u_cur;
            found <= 1'b1;
          end
          j <= j + 1'b1;
          if (j == n - 1'b1) begin
            state <= COMPUTE;
            PHI_OUT_ENABLE <= 1'b1;
            PHI_OUT <= DATA_SIZE'(cand ? j[IW-1:0] : mi);
          end
        end
        COMPUTE: begin
          a_buf[mi] <= a_new;
          p <= p_new;
          used[mi] <= 1'b1;
          k <= k + 1'b1;
          j <= '0;
          found <= 1'b0;
          state <= k == n - 1'b1 ? OUTPUT : SCAN;
          if (k == n - 1'b1) begin
            A_OUT_ENABLE <= 1'b1;
            A_OUT <= mi == '0 ? a_new : a_buf[0];
            o <= CW'(1);
          end
        end
        OUTPUT: begin
          if (o == n) begin
            state <= DONE;
            READY <= 1'b1;
          end else begin
            A_OUT_ENABLE <= 1'b1;
            A_OUT <= a_buf[o[IW-1:0]];
            o <= o + 1'b1;
          end
        end
        DONE: begin
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accelerator_allocation_weighting_sorter.sv
// tb_accelerator_allocation_weighting_sorter: randomized scoreboard bench against a sort-based reference model
module tb_accelerator_allocation_weighting_sorter;
  localparam int MN = 16;
  localparam bit [31:0] ONE = 32'h8000;
  typedef struct {int val; int cyc;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, u_en = 1'b0;
  logic ready, busy, phi_en, a_en;
  logic [15:0] size_n = '0, u_in = '0, phi, a_out;
  logic [15:0] vec [MN];
  int cyc = 0, errors = 0, checks = 0, ready_seen = 0;
  exp_t phi_q[$], a_q[$];
  int rdy_q[$];
  accelerator_allocation_weighting_sorter dut (
    .CLK(clk), .RST(rst), .START(start), .READY(ready), .BUSY(busy),
    .SIZE_N_IN(size_n), .U_IN_ENABLE(u_en), .U_IN(u_in),
    .PHI_OUT_ENABLE(phi_en), .PHI_OUT(phi), .A_OUT_ENABLE(a_en), .A_OUT(a_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask
  // Scoreboard monitor: every strobe pops its expected value and cycle
  always @(negedge clk) begin
    exp_t e;
    if (phi_en === 1'b1) begin
      if (phi_q.size() == 0) fail("phi_unexpected");
      else begin
        e = phi_q.pop_front();
        check("phi_val", int'(phi), e.val);
        check("phi_cyc", cyc, e.cyc);
      end
    end
    if (a_en === 1'b1) begin
      if (a_q.size() == 0) fail("a_unexpected");
      else begin
        e = a_q.pop_front();
        check("a_val", int'(a_out), e.val);
        check("a_cyc", cyc, e.cyc);
      end
    end
    if (ready === 1'b1) begin
      ready_seen++;
      check("busy_at_ready", int'(busy), 1);
      if (rdy_q.size() == 0) fail("ready_unexpected");
      else check("ready_cyc", cyc, rdy_q.pop_front());
    end
  end
  task automatic job_start(input int n_req, input bit gaps, input bit poke, output int ne);
    int ord[$];
    bit [31:0] mu [MN];
    bit [31:0] av [MN];
    bit [31:0] pr;
    int t, s;
    ne = n_req > MN ? MN : n_req;
    for (int i = 0; i < ne; i++) begin
`ifdef ACCELERATOR_ALLOCATION_WEIGHTING_CLAMP_EN
      mu[i] = vec[i] > ONE ? ONE : 32'(vec[i]);
`else
      mu[i] = 32'(vec[i]);
`endif
    end
    for (int i = 0; i < ne; i++) begin
      int pos = ord.size();
      for (int q = 0; q < ord.size(); q++)
        if (mu[ord[q]] > mu[i]) begin
          pos = q;
          break;
        end
      ord.insert(pos, i);
    end
    pr = ONE;
    foreach (ord[r]) begin
      av[ord[r]] = ((((ONE - mu[ord[r]]) & 32'hFFFF) * pr) >> 15) & 32'hFFFF;
      pr = ((mu[ord[r]] * pr) >> 15) & 32'hFFFF;
    end
    @(posedge clk) #1;
    start = 1'b1;
    size_n = 16'(n_req);
    t = cyc;
    @(posedge clk) #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (ne == 0) rdy_q.push_back(t + 2);
    else begin
      s = t;
      for (int i = 0; i < ne; i++) begin
        if (gaps) repeat ($urandom_range(0, 3)) begin
          u_en = 1'b0;
          u_in = 16'($urandom);
          @(posedge clk) #1;
        end
        u_en = 1'b1;
        u_in = vec[i];
        s = cyc;
        @(posedge clk) #1;
      end
      u_en = 1'b0;
      for (int r = 0; r < ne; r++) phi_q.push_back('{ord[r], s + 1 + ne + r * (ne + 1)});
      for (int i = 0; i < ne; i++) a_q.push_back('{int'(av[i]), s + ne * (ne + 1) + 1 + i});
      rdy_q.push_back(s + ne * (ne + 1) + ne + 1);
      if (poke) begin
        start = 1'b1;
        size_n = 16'd5;
        @(posedge clk) #1;
        start = 1'b0;
      end
    end
  endtask
  task automatic job(input int n_req, input bit gaps, input bit poke);
    int ne, r0, budget;
    r0 = ready_seen;
    job_start(n_req, gaps, poke, ne);
    budget = ne * (ne + 1) + ne + 20;
    while (ready_seen == r0 && budget > 0) begin
      @(posedge clk) #1;
      budget--;
    end
    if (budget == 0) fail("ready_timeout");
    check("phi_drained", phi_q.size(), 0);
    check("a_drained", a_q.size(), 0);
    @(posedge clk) #1;
    check("busy_low_after_ready", int'(busy), 0);
  endtask
  task automatic fill(input int mode);
    for (int i = 0; i < MN; i++)
      case (mode)
        0: vec[i] = 16'($urandom_range(0, ONE));
        1: vec[i] = 16'($urandom_range(0, 2) * 32'h2000);
        default: vec[i] = 16'($urandom);
      endcase
  endtask
  initial begin
    int ne, budget;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_phi_en", int'(phi_en), 0);
    check("rst_phi", int'(phi), 0);
    check("rst_a_en", int'(a_en), 0);
    check("rst_a", int'(a_out), 0);
    rst = 1'b0;
    vec[0] = 16'h4000; vec[1] = 16'h2000; vec[2] = 16'h6000;
    job(3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) vec[i] = 16'h0000;
    job(4, 1'b0, 1'b0);
    vec[0] = 16'hC000;
    job(1, 1'b0, 1'b0);
    job(0, 1'b0, 1'b0);
    fill(0);
    job(MN + 5, 1'b0, 1'b0);
    vec[0] = 16'h4000; vec[1] = 16'h2000; vec[2] = 16'h6000;
    job(3, 1'b1, 1'b1);
    job_start(3, 1'b0, 1'b0, ne);
    budget = 40;
    while (phi_en !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) fail("compute_timeout");
    rst = 1'b1;
    @(posedge clk) #1;
    phi_q.delete();
    a_q.delete();
    rdy_q.delete();
    check("midrst_ready", int'(ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_phi_en", int'(phi_en), 0);
    check("midrst_phi", int'(phi), 0);
    check("midrst_a_en", int'(a_en), 0);
    check("midrst_a", int'(a_out), 0);
    rst = 1'b0;
    job(3, 1'b0, 1'b0);
    for (int r = 0; r < 15; r++) begin
      fill(int'($urandom_range(0, 2)));
      job(int'($urandom_range(1, r < 8 ? 6 : MN)), 1'($urandom), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
